// File: rtl/data_mem_dma.sv
// data_mem_dma: copy engine that drives the data memory port (A/WD/WE/Cant_Byte/RD).
// Latency: two cycles per transfer (RD then WR), plus one DONE cycle; a zero-length request takes only the DONE cycle.
// Backpressure: none. start is taken only in IDLE, and a start raised while busy is dropped.
//
// Ports: clk/reset (async, active-high); start, src_addr, dst_addr, length (latched on start);
//        busy, done, err status; mem_A, mem_WD, mem_WE, mem_Cant_Byte out to memory; mem_RD from memory.
// Optional build macro DMA_FILL_EN adds fill_mode/fill_byte. In fill mode the engine skips the read
// and writes a constant pattern, taking one cycle per transfer.
module data_mem_dma #(
    parameter int ADDR_W = 19,
    parameter int DATA_W = 19,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef DMA_FILL_EN
    input  logic              fill_mode,
    input  logic [7:0]        fill_byte,
`endif
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_A,
    output logic [DATA_W-1:0] mem_WD,
    output logic              mem_WE,
    output logic              mem_Cant_Byte,
    input  logic [DATA_W-1:0] mem_RD
);

    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, dst_q;
    logic [LEN_W-1:0]  rem_q;
    logic [15:0]       data_q;
    logic              step_q;      // 1 = halfword, decided in RD and held for WR
    logic              err_q;
`ifdef DMA_FILL_EN
    logic              fill_q;
    logic [7:0]        fill_byte_q;
`endif

    logic              hw_rd, hw_wr, prot;
    logic              go_fill, in_fill;
    logic [15:0]       wdata;
    logic [1:0]        step_amt;
    logic [LEN_W-1:0]  rem_nxt;
    logic              rd_unused;

    // Only the low halfword of RD carries data.
    assign rd_unused = ^mem_RD[DATA_W-1:16];

    always_comb begin
        hw_rd = ~src_q[0] & ~dst_q[0] & (rem_q >= LEN_W'(2));
`ifdef DMA_FILL_EN
        go_fill = fill_mode;
        in_fill = fill_q;
        if (fill_q) begin
            // No read phase in fill mode, so the step width is decided in WR.
            hw_wr = ~dst_q[0] & (rem_q >= LEN_W'(2));
            wdata = hw_wr ? {fill_byte_q, fill_byte_q} : {8'h00, fill_byte_q};
        end else begin
            hw_wr = step_q;
            wdata = step_q ? data_q : {8'h00, data_q[7:0]};
        end
`else
        go_fill = 1'b0;
        in_fill = 1'b0;
        hw_wr   = step_q;
        wdata   = step_q ? data_q : {8'h00, data_q[7:0]};
`endif
        step_amt = hw_wr ? 2'd2 : 2'd1;
        rem_nxt  = rem_q - LEN_W'(step_amt);
        // The halfword at byte addresses 0/1 is the quadrant register. It is never written.
        prot     = (dst_q[ADDR_W-1:1] == '0);
    end

    // Next state and bus outputs. Bus outputs idle at zero outside RD and WR.
    always_comb begin
        state_d       = state_q;
        busy          = 1'b0;
        done          = 1'b0;
        mem_A         = '0;
        mem_WD        = '0;
        mem_WE        = 1'b0;
        mem_Cant_Byte = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (length == '0)
                        state_d = DONE;
                    else
                        state_d = go_fill ? WR : RD;
                end
            end
            RD: begin
                busy          = 1'b1;
                mem_A         = src_q;
                mem_Cant_Byte = hw_rd;
                state_d       = WR;
            end
            WR: begin
                busy          = 1'b1;
                mem_A         = dst_q;
                mem_WD        = {{(DATA_W-16){1'b0}}, wdata};
                mem_WE        = ~prot;
                mem_Cant_Byte = hw_wr;
                if (rem_nxt == '0)
                    state_d = DONE;
                else
                    state_d = in_fill ? WR : RD;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign err = err_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            src_q       <= '0;
            dst_q       <= '0;
            rem_q       <= '0;
            data_q      <= '0;
            step_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef DMA_FILL_EN
            fill_q      <= 1'b0;
            fill_byte_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        src_q       <= src_addr;
                        dst_q       <= dst_addr;
                        rem_q       <= length;
                        err_q       <= 1'b0;
`ifdef DMA_FILL_EN
                        fill_q      <= fill_mode;
                        fill_byte_q <= fill_byte;
`endif
                    end
                end
                RD: begin
                    data_q <= mem_RD[15:0];
                    step_q <= hw_rd;
                end
                WR: begin
                    // Addresses wrap modulo 2^ADDR_W.
                    src_q <= src_q + ADDR_W'(step_amt);
                    dst_q <= dst_q + ADDR_W'(step_amt);
                    rem_q <= rem_nxt;
                    if (prot)
                        err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
